// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle 32-bit integer divider for the execute stage's
//            DIV/DIVU handshake. Radix-2 restoring division, one quotient
//            bit per clock, operands converted to magnitudes on entry and the
//            sign correction applied on the final iteration.
// Ports    : cpu_clk        clock, rising edge
//            cpu_rst        asynchronous active-high reset
//            div_start_i    request, held high until div_ready_o is seen
//            signed_div_i   1 = DIV (signed), 0 = DIVU
//            div_opdata1_i  dividend
//            div_opdata2_i  divisor
//            annul_i        abort the current division (flush/exception)
//            div_result_o   {remainder, quotient} -> {HI, LO}
//            div_zero_o     END reached through divide-by-zero
//                           (only when DIV_ZERO_FLAG_EN is defined)
//            div_ready_o    result valid
// Options  : `define DIV_ZERO_FLAG_EN to add the div_zero_o output.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int DIV_W = 32,
    parameter int CNT_W = 6
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    input  logic                 div_start_i,
    input  logic                 signed_div_i,
    input  logic [DIV_W-1:0]     div_opdata1_i,
    input  logic [DIV_W-1:0]     div_opdata2_i,
    input  logic                 annul_i,
    output logic [2*DIV_W-1:0]   div_result_o,
`ifdef DIV_ZERO_FLAG_EN
    output logic                 div_zero_o,
`endif
    output logic                 div_ready_o
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_divzero = 2'd1;
    localparam logic [1:0] c_st_on      = 2'd2;
    localparam logic [1:0] c_st_end     = 2'd3;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(DIV_W - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_rem;
    logic [DIV_W-1:0]   r_dvd;      // dividend bits shift out, quotient bits shift in
    logic [DIV_W-1:0]   r_dvs;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [2*DIV_W-1:0] r_result;
    logic               r_ready;

    logic               w_last;
    logic [DIV_W:0]     w_rem_sh;
    logic [DIV_W:0]     w_trial;
    logic               w_q_bit;
    logic [DIV_W-1:0]   w_rem_next;
    logic [DIV_W-1:0]   w_quo_next;
    logic [DIV_W-1:0]   w_rem_fix;
    logic [DIV_W-1:0]   w_quo_fix;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [DIV_W-1:0]   w_op1_mag;
    logic [DIV_W-1:0]   w_op2_mag;

    assign w_last     = (r_cnt == c_last_iter);

    // The partial remainder is always below the divisor, so after the shift
    // it fits in DIV_W+1 bits and the trial subtraction's MSB is its sign.
    assign w_rem_sh   = {r_rem, r_dvd[DIV_W-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_dvs};
    assign w_q_bit    = ~w_trial[DIV_W];
    assign w_rem_next = w_q_bit ? w_trial[DIV_W-1:0] : w_rem_sh[DIV_W-1:0];
    assign w_quo_next = {r_dvd[DIV_W-2:0], w_q_bit};
    assign w_quo_fix  = r_sign_q ? -w_quo_next : w_quo_next;
    assign w_rem_fix  = r_sign_r ? -w_rem_next : w_rem_next;

    // Negating the most negative value yields 2^(DIV_W-1) as an unsigned
    // magnitude, which is exactly what the restoring loop needs.
    assign w_op1_neg  = signed_div_i & div_opdata1_i[DIV_W-1];
    assign w_op2_neg  = signed_div_i & div_opdata2_i[DIV_W-1];
    assign w_op1_mag  = w_op1_neg ? -div_opdata1_i : div_opdata1_i;
    assign w_op2_mag  = w_op2_neg ? -div_opdata2_i : div_opdata2_i;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (annul_i) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (div_start_i) begin
                        w_state_next = (div_opdata2_i == '0) ? c_st_divzero : c_st_on;
                    end
                end
                c_st_divzero: w_state_next = c_st_end;
                c_st_on: begin
                    if (w_last) begin
                        w_state_next = c_st_end;
                    end
                end
                default: begin
                    if (!div_start_i) begin
                        w_state_next = c_st_idle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else if (annul_i) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (div_start_i) begin
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_dvd    <= w_op1_mag;
                        r_dvs    <= w_op2_mag;
                        r_sign_q <= w_op1_neg ^ w_op2_neg;
                        r_sign_r <= w_op1_neg;
                    end
                end
                c_st_divzero: begin
                    r_result <= '0;
                    r_ready  <= 1'b1;
                end
                c_st_on: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                    end
                end
                default: begin
                    if (!div_start_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_zero <= 1'b0;
        end else if (annul_i) begin
            r_zero <= 1'b0;
        end else if (r_state == c_st_divzero) begin
            r_zero <= 1'b1;
        end else if ((r_state == c_st_end) && !div_start_i) begin
            r_zero <= 1'b0;
        end
    end

    assign div_zero_o = r_zero;
`endif

    assign div_result_o = r_result;
    assign div_ready_o  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit. A transaction-level model
//            (plain integer division plus a countdown to completion) predicts
//            ready/result every cycle; directed cases pin the model and the
//            DUT to hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        div_start_i;
    logic        signed_div_i;
    logic [31:0] div_opdata1_i;
    logic [31:0] div_opdata2_i;
    logic        annul_i;
    logic [63:0] div_result_o;
    logic        div_ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero_o;
`endif

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 cpu_clk = ~cpu_clk;

    div_unit #(.DIV_W(32), .CNT_W(6)) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst       (cpu_rst),
        .div_start_i   (div_start_i),
        .signed_div_i  (signed_div_i),
        .div_opdata1_i (div_opdata1_i),
        .div_opdata2_i (div_opdata2_i),
        .annul_i       (annul_i),
        .div_result_o  (div_result_o),
`ifdef DIV_ZERO_FLAG_EN
        .div_zero_o    (div_zero_o),
`endif
        .div_ready_o   (div_ready_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference arithmetic: {remainder, quotient}; divide-by-zero gives 0.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Transaction model: a request seen while idle completes after 32 more
    // edges (1 for a zero divisor); the result stays until start drops.
    logic        m_busy, m_ready, m_zero, m_divz;
    int          m_left;
    logic [63:0] m_res, m_out;

    always @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_zero <= 1'b0; m_divz <= 1'b0;
            m_left <= 0;    m_res   <= '0;   m_out  <= '0;
        end else if (annul_i) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_zero <= 1'b0; m_out <= '0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_out   <= m_res;
                m_zero  <= m_divz;
            end
        end else if (m_ready) begin
            if (!div_start_i) begin
                m_ready <= 1'b0;
                m_out   <= '0;
                m_zero  <= 1'b0;
            end
        end else if (div_start_i) begin
            m_busy <= 1'b1;
            m_divz <= (div_opdata2_i == 32'd0);
            m_left <= (div_opdata2_i == 32'd0) ? 1 : 32;
            m_res  <= ref_div(signed_div_i, div_opdata1_i, div_opdata2_i);
        end
    end

    always @(negedge cpu_clk) begin
        if (chk_en) begin
            chk("cyc_ready", {63'd0, div_ready_o}, {63'd0, m_ready});
            chk("cyc_result", div_result_o, m_out);
`ifdef DIV_ZERO_FLAG_EN
            chk("cyc_zero", {63'd0, div_zero_o}, {63'd0, m_zero});
`endif
        end
    end

    // Called just after a rising edge with the DUT idle. Latency counts the
    // sampling edge as edge 1.
    task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int n;
        signed_div_i  = sgn;
        div_opdata1_i = a;
        div_opdata2_i = b;
        div_start_i   = 1'b1;
        @(posedge cpu_clk); #1;
        n = 1;
        while (!div_ready_o && n < 100) begin
            @(posedge cpu_clk); #1;
            n++;
        end
        chk({name, "_lat"}, 64'(n), 64'(exp_lat));
        chk({name, "_res"}, div_result_o, exp);
        chk({name, "_mdl"}, m_out, exp);
`ifdef DIV_ZERO_FLAG_EN
        chk({name, "_zflag"}, {63'd0, div_zero_o}, {63'd0, (b == 32'd0)});
`endif
        repeat (2) begin @(posedge cpu_clk); #1; end
        chk({name, "_hold"}, {div_result_o[63:1], div_ready_o}, {exp[63:1], 1'b1});
        div_start_i = 1'b0;
        @(posedge cpu_clk); #1;
        chk({name, "_drop"}, {div_result_o[62:0], div_ready_o}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int          sel, k, n;
        bit          sgn;
        logic [31:0] a, b;

        cpu_rst = 1'b1; div_start_i = 1'b0; signed_div_i = 1'b0;
        div_opdata1_i = '0; div_opdata2_i = '0; annul_i = 1'b0;
        #2;
        chk("rst_ready", {63'd0, div_ready_o}, 64'd0);
        chk("rst_result", div_result_o, 64'd0);
        chk_en = 1'b1;
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        @(posedge cpu_clk); #1;

        run_div("u100_7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);
        run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("s7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33);
        run_div("s_min_m1", 1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33);
        run_div("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33);
        run_div("zero_dvd", 1'b0, 32'd0,          32'd9,          64'd0,                 33);
        run_div("div0",     1'b0, 32'h1234,       32'd0,          64'd0,                 2);

        // Annul on iteration 10, then a fresh division.
        signed_div_i = 1'b0; div_opdata1_i = 32'd1000; div_opdata2_i = 32'd3; div_start_i = 1'b1;
        @(posedge cpu_clk); #1;
        repeat (9) begin @(posedge cpu_clk); #1; end
        annul_i = 1'b1; div_start_i = 1'b0;
        @(posedge cpu_clk); #1;
        annul_i = 1'b0;
        repeat (40) begin @(posedge cpu_clk); #1; end
        chk("annul_noready", {63'd0, div_ready_o}, 64'd0);
        run_div("u5_5", 1'b0, 32'd5, 32'd5, 64'h00000000_00000001, 33);

        // Start concurrent with annul in idle is ignored.
        div_opdata1_i = 32'd50; div_opdata2_i = 32'd0; div_start_i = 1'b1; annul_i = 1'b1;
        @(posedge cpu_clk); #1;
        div_start_i = 1'b0; annul_i = 1'b0;
        repeat (4) begin @(posedge cpu_clk); #1; end
        chk("annul_start_ign", {63'd0, div_ready_o}, 64'd0);

        // Asynchronous reset in the middle of the iterations.
        signed_div_i = 1'b0; div_opdata1_i = 32'd1000; div_opdata2_i = 32'd3; div_start_i = 1'b1;
        @(posedge cpu_clk); #1;
        repeat (20) @(posedge cpu_clk);
        #3 cpu_rst = 1'b1;
        #1 chk("rst_mid_on", {div_result_o[62:0], div_ready_o}, 64'd0);
        div_start_i = 1'b0;
        @(posedge cpu_clk); #1 cpu_rst = 1'b0;
        @(posedge cpu_clk); #1;
        run_div("u9_4", 1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 33);

        // Asynchronous reset while a result is being held.
        div_opdata1_i = 32'd100; div_opdata2_i = 32'd7; div_start_i = 1'b1;
        n = 0;
        while (!div_ready_o && n < 100) begin @(posedge cpu_clk); #1; n++; end
        chk("end_reached", {63'd0, div_ready_o}, 64'd1);
        #2 cpu_rst = 1'b1;
        #1 chk("rst_in_end", div_result_o, 64'd0);
        chk("rst_in_end_rdy", {63'd0, div_ready_o}, 64'd0);
        div_start_i = 1'b0;
        @(posedge cpu_clk); #1 cpu_rst = 1'b0;
        @(posedge cpu_clk); #1;

        // Randomized requests; the per-cycle compare does the checking.
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 5);
            sgn = 1'($urandom);
            a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            signed_div_i = sgn; div_opdata1_i = a; div_opdata2_i = b; div_start_i = 1'b1;
            @(posedge cpu_clk); #1;
            // Operand changes after sampling must not matter.
            signed_div_i = 1'($urandom); div_opdata1_i = $urandom; div_opdata2_i = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, 30);
                repeat (k) begin @(posedge cpu_clk); #1; end
                annul_i = 1'b1; div_start_i = 1'b0;
                @(posedge cpu_clk); #1;
                annul_i = 1'b0;
            end else begin
                n = 0;
                while (!div_ready_o && n < 100) begin @(posedge cpu_clk); #1; n++; end
                if (n >= 100) chk("rand_timeout", 64'(n), 64'd32);
                k = $urandom_range(0, 3);
                repeat (k) begin @(posedge cpu_clk); #1; end
                div_start_i = 1'b0;
                @(posedge cpu_clk); #1;
            end
        end

        @(negedge cpu_clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider serving the execute stage's DIV/DIVU handshake (start/operands/signed in, ready/result out).
- Sits beside the execute stage. It holds the pipeline stall condition (ready low) until the quotient and remainder are valid.
- The 64-bit result is written to HI/LO by the execute stage.
- Radix-2 restoring algorithm, one quotient bit per cycle, with sign correction applied on completion.

Parameters:
- DIV_W, 32, operand width. Result width is 2*DIV_W.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > DIV_W.

Ports:
- cpu_clk  in  1  clock; all state changes on the rising edge.
- cpu_rst  in  1  reset; asynchronous, active-high.
- div_start_i  in  1  request from execute stage; held high until div_ready_o is seen.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
- div_opdata1_i  in  32  dividend.
- div_opdata2_i  in  32  divisor.
- annul_i  in  1  abort the current division (exception/flush).
- div_result_o  out  64  [63:32] = remainder (to HI), [31:0] = quotient (to LO).
- div_ready_o  out  1  result valid.

Behaviour:
- Reset: while cpu_rst is high, state = IDLE and all outputs and internal registers are 0, immediately (asynchronous).
- States: IDLE, DIVZERO, ON, END. State is encoded in 2 bits.
- IDLE:
  - div_ready_o = 0, div_result_o = 0.
  - If div_start_i=1 and annul_i=0, sample signed_div_i and both operands at that edge.
  - Divisor == 0 → DIVZERO.
  - Otherwise → ON: counter = 0, partial remainder = 0. Dividend register = |opdata1| if signed, else raw; divisor register likewise.
  - Record sign_q = op1[31]^op2[31] and sign_r = op1[31], both only when signed.
- DIVZERO: next edge → END with result = 64'h0. Total latency 2 edges after the sampling edge.
- ON, each edge:
  - Shift {rem, dividend} left by 1.
  - trial = rem_shifted − divisor (33-bit subtract). If non-negative, rem = trial and the quotient LSB = 1; else the quotient LSB = 0.
  - counter += 1.
  - On the edge where counter == 31 (the 32nd iteration):
    - Apply sign correction: quotient negated if sign_q; remainder negated if sign_r.
    - Register the result and go → END.
- END:
  - div_ready_o = 1, div_result_o holds the result.
  - Stay in END while div_start_i = 1.
  - div_start_i = 0 → IDLE; div_ready_o and div_result_o clear to 0 on that edge.
- Latency: div_ready_o rises 33 edges after the IDLE sampling edge for a non-zero divisor.
- Operands and signed_div_i are ignored after sampling. Changes during ON/END have no effect.
- annul_i:
  - Highest priority after reset.
  - In any state, annul_i=1 → IDLE on the next edge, outputs 0, counter cleared.
  - A start that is concurrent with annul_i in IDLE is ignored.
- Boundary cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. The abs of 0x80000000 is treated as unsigned 2^31; no trap.
  - Dividend 0 gives result 0 after the full 33 cycles; there is no early exit.
  - Unsigned 0xFFFFFFFF / 1 gives quotient 0xFFFFFFFF, remainder 0.
- A start that arrives in ON, DIVZERO or END has no effect. A back-to-back DIV is accepted only after the return to IDLE.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - Adds output div_zero_o (1 bit). It is 1 while in END when the division came from DIVZERO, otherwise 0.
  - Cleared by reset, by annul_i and by the return to IDLE.
- Undefined:
  - No div_zero_o port.
  - Division by zero is indistinguishable from a zero result, apart from the 2-cycle latency.

Test Plan:
- Unsigned 100 / 7, start held → div_ready_o high exactly 33 cycles after the sampling edge. div_result_o = 64'h00000002_0000000E. Start dropped → ready 0 next cycle.
- Signed 0xFFFFFFF9 (−7) / 2 → result 64'hFFFFFFFF_FFFFFFFD (rem −1, quo −3). Also signed 7 / 0xFFFFFFFE (−2) → result 64'h00000001_FFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000. Unsigned 0xFFFFFFFF / 1 → 64'h00000000_FFFFFFFF.
- Divisor 0, dividend 0x1234 → END after 2 edges, result 64'h0. With DIV_ZERO_FLAG_EN, div_zero_o = 1 while ready is high.
- Start 1000 / 3, annul_i pulsed on iteration 10 → IDLE next edge, ready never asserted. A following start 5 / 5 → 64'h00000000_00000001 after 33 cycles.
- cpu_rst asserted mid-ON (iteration 20) → outputs 0 immediately (asynchronous). After release, divide 9 / 4 unsigned → 64'h00000001_00000002.
